fpu_utils_rspack: RTL
=====================

FPU_UTILS_RSPACK -- requirements
Module: fpu_utils_rspack

Interface
REQ-001 SHALL have parameter FP_FMT, default fpu_pkg::fp_format_e'(0), target format; FLEN/EXP_BITS/MAN_BITS SHALL be derived via fpu_pkg::flen_bits/exp_bits/man_bits.
REQ-002 SHALL have ports, one clock, reset synchronous active-high:
- i_clk  in  1  clock
- i_rst  in  1  sync active-high reset
- i_valid  in  1  input result valid
- o_ready  out  1  input accepted when i_valid&o_ready
- i_cls  in  3  class: 0 FINITE, 1 ZERO, 2 INF, 3 QNAN, 4 NAN_INVALID, 5-7 reserved
- i_sign  in  1  sign
- i_exp  in  EXP_BITS+2  signed two's-complement biased exponent
- i_man  in  MAN_BITS+1  mantissa incl. hidden bit at MSB
- o_valid  out  1  packed result valid
- i_ready  in  1  downstream ready
- o_res  out  FLEN  packed IEEE-754 result
- o_fflags  out  5  {NV,DZ,OF,UF,NX} of o_res
- i_flag_clr  in  1  clear accumulated flags
- o_fflags_acc  out  5  sticky OR of delivered o_fflags

Function
REQ-003 SHALL be a 2-stage pipeline (S1 decode/shift, S2 pack/output register); latency exactly 2 cycles from accept to o_valid with no stall.
REQ-004 Stage advance: S2 loads when !S2.valid | i_ready; S1 advances when S2 loads; o_ready = !S1.valid | S2 load-enable (full throughput, no bubbles).
REQ-005 o_res/o_fflags SHALL hold stable while o_valid & !i_ready.
REQ-006 ZERO: {i_sign, 0, 0}, flags 0.
REQ-007 INF: {i_sign, all-ones exp, 0}, flags 0.
REQ-008 QNAN, NAN_INVALID, reserved: canonical NaN (sign 0, exp all-ones, man MSB 1, rest 0); NV=1 for NAN_INVALID and reserved, else flags 0.
REQ-009 FINITE with i_man==0: signed zero, flags 0, regardless of i_exp.
REQ-010 FINITE with i_exp >= 2^EXP_BITS-1: {i_sign, all-ones, 0}, OF=NX=1.
REQ-011 FINITE with 1 <= i_exp <= 2^EXP_BITS-2: {i_sign, i_exp[EXP_BITS-1:0], i_man[MAN_BITS-1:0]}, flags 0; hidden bit not checked.
REQ-012 FINITE with i_exp <= 0: shift i_man right by sh=1-i_exp (truncate), exp field 0, man field shifted[MAN_BITS-1:0]; sh >= MAN_BITS+2 yields zero mantissa; NX=UF=1 iff any nonzero bit shifted out, else flags 0.
REQ-013 DZ SHALL always be 0.
REQ-014 o_fflags_acc next = (i_flag_clr ? 0 : acc) | (o_valid & i_ready ? o_fflags : 0); clear and same-cycle delivery yields only the delivered flags.
REQ-015 Shift amount computation SHALL be saturating; no wrap for very negative i_exp (min -2^(EXP_BITS+1)).

Reset
REQ-016 On i_rst: S1/S2 valid=0, o_valid=0, o_ready=1 the cycle after, o_fflags_acc=0, o_res=0, o_fflags=0.
REQ-017 Reset mid-operation SHALL drop all in-flight results; no transaction completes on or after the reset cycle.
REQ-018 i_rst SHALL take priority over i_valid, i_ready, i_flag_clr.

Verification (FP_FMT = FP32: FLEN 32, EXP 8, MAN 23)
REQ-019 FINITE s=0 exp=127 man=0x800000, i_ready=1 -> o_res=0x3F800000, o_fflags=0, o_valid exactly 2 cycles after accept.
REQ-020 FINITE s=1 exp=255 -> 0xFF800000, o_fflags=5'b00101; FINITE s=0 exp=0 man=0x800001 -> 0x00400000, o_fflags=5'b00011; exp=-40 man=0x800000 -> 0x00000000, 5'b00011.
REQ-021 QNAN s=1 -> 0x7FC00000, flags 0; NAN_INVALID -> 0x7FC00000, 5'b10000; i_cls=7 -> 0x7FC00000, 5'b10000; INF s=1 -> 0xFF800000, 0.
REQ-022 Backpressure: i_ready=0 for 4 cycles, i_valid=1 continuously with 3 distinct inputs -> exactly 2 accepted, o_ready=0 thereafter, o_res stable; on i_ready=1 results emerge in order, one per cycle, none lost or duplicated.
REQ-023 Flags: deliver OF result then NV result -> o_fflags_acc=5'b10101; i_flag_clr with same-cycle UF|NX delivery -> 5'b00011 next cycle.
REQ-024 Assert i_rst with both stages full -> next cycle o_valid=0, o_fflags_acc=0, o_ready=1; no output from pre-reset inputs.

Source files
------------

// File: rtl/fpu_utils_rspack.sv
// Result packer: turns a classified, unrounded sign/exp/mantissa triple
// into an IEEE-754 word plus exception flags over a 2-stage pipeline.
package fpu_pkg;
  typedef enum logic [1:0] {
    FP32    = 2'd0,
    FP64    = 2'd1,
    FP16    = 2'd2,
    FP16ALT = 2'd3
  } fp_format_e;

  function automatic int unsigned flen_bits(fp_format_e f);
    case (f)
      FP64:          return 64;
      FP16, FP16ALT: return 16;
      default:       return 32;
    endcase
  endfunction

  function automatic int unsigned exp_bits(fp_format_e f);
    case (f)
      FP64:    return 11;
      FP16:    return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e f);
    case (f)
      FP64:    return 52;
      FP16:    return 10;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction
endpackage

module fpu_utils_rspack #(
  parameter fpu_pkg::fp_format_e FP_FMT = fpu_pkg::fp_format_e'(0),
  localparam int unsigned FLEN     = fpu_pkg::flen_bits(FP_FMT),
  localparam int unsigned EXP_BITS = fpu_pkg::exp_bits(FP_FMT),
  localparam int unsigned MAN_BITS = fpu_pkg::man_bits(FP_FMT)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [2:0]          i_cls,
  input  logic                i_sign,
  input  logic [EXP_BITS+1:0] i_exp,
  input  logic [MAN_BITS:0]   i_man,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [FLEN-1:0]     o_res,
  output logic [4:0]          o_fflags,
  input  logic                i_flag_clr,
  output logic [4:0]          o_fflags_acc
);
  localparam int unsigned EW = EXP_BITS + 2;
  localparam logic signed [EW-1:0] EXP_MAX =
    EW'((2 ** EXP_BITS) - 1);
  localparam logic signed [EW:0] SH_SAT =
    (EW+1)'(MAN_BITS + 2);

  logic signed [EW-1:0] exp_s;
  logic signed [EW:0]   sh_raw;
  logic signed [EW:0]   sh_sat;
  logic [MAN_BITS-1:0]  shifted;
  logic [MAN_BITS:0]    lost_mask;
  logic                 lost;

  logic                c_fin, c_zero, c_inf, c_qnan, c_inv;
  logic                dec_sign;
  logic [EXP_BITS-1:0] dec_exp;
  logic [MAN_BITS-1:0] dec_man;
  logic [4:0]          dec_flg;

  logic                s1_v_q, s1_v_d;
  logic                s1_sign_q, s1_sign_d;
  logic [EXP_BITS-1:0] s1_exp_q, s1_exp_d;
  logic [MAN_BITS-1:0] s1_man_q, s1_man_d;
  logic [4:0]          s1_flg_q, s1_flg_d;
  logic                s2_v_q, s2_v_d;
  logic [FLEN-1:0]     s2_res_q, s2_res_d;
  logic [4:0]          s2_flg_q, s2_flg_d;
  logic [4:0]          acc_q, acc_d;
  logic                s2_en;
  logic                acc_in;

  // Shift is computed one bit wider and clamped so very negative
  // exponents cannot wrap into a small shift.
  assign exp_s     = $signed(i_exp);
  assign sh_raw    = (EW+1)'(1) - {exp_s[EW-1], exp_s};
  assign sh_sat    = (sh_raw > SH_SAT) ? SH_SAT : sh_raw;
  assign shifted   = MAN_BITS'(i_man >> $unsigned(sh_sat));
  assign lost_mask =
    ~({(MAN_BITS+1){1'b1}} << $unsigned(sh_sat));
  assign lost      = |(i_man & lost_mask);

  assign c_fin  = (i_cls == 3'd0);
  assign c_zero = (i_cls == 3'd1);
  assign c_inf  = (i_cls == 3'd2);
  assign c_qnan = (i_cls == 3'd3);
  assign c_inv  = (i_cls >= 3'd4);

  always_comb begin
    dec_sign = i_sign;
    dec_exp  = '0;
    dec_man  = '0;
    dec_flg  = '0;
    unique case (1'b1)
      c_zero: ;
      c_inf:  dec_exp = '1;
      c_qnan, c_inv: begin
        dec_sign = 1'b0;
        dec_exp  = '1;
        dec_man  = {1'b1, {(MAN_BITS-1){1'b0}}};
        dec_flg  = {c_inv, 4'b0000};
      end
      c_fin: begin
        if (i_man == '0) begin
          dec_exp = '0;
        end else if (exp_s >= EXP_MAX) begin
          dec_exp = '1;
          dec_flg = 5'b00101;
        end else if (exp_s >= EW'(1)) begin
          dec_exp = i_exp[EXP_BITS-1:0];
          dec_man = i_man[MAN_BITS-1:0];
        end else begin
          dec_man = shifted;
          dec_flg = lost ? 5'b00011 : 5'b00000;
        end
      end
      default: ;
    endcase
  end

  assign s2_en   = !s2_v_q | i_ready;
  assign o_ready = !s1_v_q | s2_en;
  assign acc_in  = s2_v_q & i_ready;

  always_comb begin
    s1_v_d    = o_ready ? i_valid : s1_v_q;
    s1_sign_d = s1_sign_q;
    s1_exp_d  = s1_exp_q;
    s1_man_d  = s1_man_q;
    s1_flg_d  = s1_flg_q;
    if (i_valid & o_ready) begin
      s1_sign_d = dec_sign;
      s1_exp_d  = dec_exp;
      s1_man_d  = dec_man;
      s1_flg_d  = dec_flg;
    end
    s2_v_d   = s2_en ? s1_v_q : s2_v_q;
    s2_res_d = s2_res_q;
    s2_flg_d = s2_flg_q;
    if (s2_en & s1_v_q) begin
      s2_res_d = {s1_sign_q, s1_exp_q, s1_man_q};
      s2_flg_d = s1_flg_q;
    end
    acc_d = (i_flag_clr ? 5'b0 : acc_q)
          | (acc_in ? s2_flg_q : 5'b0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_v_q    <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_man_q  <= '0;
      s1_flg_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_res_q  <= '0;
      s2_flg_q  <= '0;
      acc_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_man_q  <= s1_man_d;
      s1_flg_q  <= s1_flg_d;
      s2_v_q    <= s2_v_d;
      s2_res_q  <= s2_res_d;
      s2_flg_q  <= s2_flg_d;
      acc_q     <= acc_d;
    end
  end

  assign o_valid      = s2_v_q;
  assign o_res        = s2_res_q;
  assign o_fflags     = s2_flg_q;
  assign o_fflags_acc = acc_q;
endmodule
